// File: rtl/cond_scan_kernel_if.sv
// Host array port and scan result bus for cond_scan_kernel.
// master = host side, slave = kernel side.
interface cond_scan_kernel_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 5
);
    logic [WIDTH-1:0]  init_i;
    logic              controlArr;
    logic              controlArrWEnable_a;
    logic [ADDR_W-1:0] controlArrAddr_a;
    logic [WIDTH-1:0]  controlArrWData_a;
    logic [WIDTH-1:0]  controlArrRData_a;
    logic              w_enable;
    logic [CNT_W-1:0]  result;

    modport master (
        output init_i, controlArr, controlArrWEnable_a, controlArrAddr_a, controlArrWData_a,
        input  controlArrRData_a, w_enable, result
    );

    modport slave (
        input  init_i, controlArr, controlArrWEnable_a, controlArrAddr_a, controlArrWData_a,
        output controlArrRData_a, w_enable, result
    );
endinterface

// File: rtl/cond_scan_kernel.sv
// Scans an array for entries equal to a key, increments each match in place
// and reports the match count; the host can take over the array at any time.
module cond_scan_kernel #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input logic               clk,
    input logic               r_enable,
    cond_scan_kernel_if.slave bus
);
    typedef enum logic [2:0] {RD, CMP, WR, NEXT, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state, state_d;
    logic [ADDR_W-1:0] idx, idx_d;
    logic [WIDTH-1:0]  key;
    logic [WIDTH-1:0]  lat, lat_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [CNT_W-1:0]  result_q, result_d;
    logic              wen_q, wen_d;
    logic              stall;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] arr_addr;
    logic              arr_we;
    logic [WIDTH-1:0]  arr_wdata;
    logic [WIDTH-1:0]  arr_rdata;

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        cnt_d     = cnt;
        lat_d     = lat;
        result_d  = result_q;
        wen_d     = wen_q;
        arr_addr  = idx;
        arr_we    = 1'b0;
        arr_wdata = lat + WIDTH'(1);
        // Host ownership aborts the element in flight; RD re-reads the same idx.
        stall     = bus.controlArr && (state inside {RD, CMP, WR});

        if (stall) begin
            state_d = RD;
        end else begin
            case (state)
                RD:   state_d = CMP;
                CMP: begin
                    if (arr_rdata == key) begin
                        lat_d   = arr_rdata;
                        state_d = WR;
                    end else begin
                        state_d = NEXT;
                    end
                end
                WR: begin
                    arr_we  = ~r_enable;
                    cnt_d   = cnt + CNT_W'(1);
                    state_d = NEXT;
                end
                NEXT: begin
                    if (idx == LAST_IDX) begin
                        state_d  = DONE;
                        result_d = cnt;
                        wen_d    = 1'b1;
                    end else begin
                        idx_d   = idx + ADDR_W'(1);
                        state_d = RD;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = RD;
            endcase
        end

        if (bus.controlArr) begin
            arr_addr  = bus.controlArrAddr_a;
            arr_we    = bus.controlArrWEnable_a;
            arr_wdata = bus.controlArrWData_a;
        end
    end

    always_ff @(posedge clk) begin
        if (r_enable) begin
            state    <= RD;
            idx      <= '0;
            cnt      <= '0;
            key      <= bus.init_i;
            lat      <= '0;
            wen_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            cnt      <= cnt_d;
            lat      <= lat_d;
            wen_q    <= wen_d;
            result_q <= result_d;
        end
    end

    // Array is never cleared by reset; host accesses proceed during reset.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem[arr_addr] <= arr_wdata;
        end
        rd_addr_q <= arr_addr;
    end

    assign arr_rdata             = mem[rd_addr_q];
    assign bus.controlArrRData_a = bus.controlArr ? arr_rdata : '0;
    assign bus.w_enable          = wen_q;
    assign bus.result            = result_q;
endmodule

// File: tb/tb_cond_scan_kernel.sv
// Scoreboard bench for cond_scan_kernel: stimulus pushes expected scan results
// and host read data; a negedge monitor pops and compares.
module tb_cond_scan_kernel;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef struct {
        int res;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic r_enable = 1'b1;
    always #5 clk = ~clk;

    cond_scan_kernel_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    cond_scan_kernel #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .r_enable (r_enable),
        .bus      (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int unsigned scan_edges = 0;
    logic rd_req = 1'b0;
    logic rd_pend = 1'b0;
    logic wen_prev = 1'b0;
    logic [CNT_W-1:0] last_res = '0;
    exp_t cur;
    exp_t scan_q[$];
    logic [WIDTH-1:0] rd_q[$];
    logic [WIDTH-1:0] ref_mem [DEPTH];
    logic [WIDTH-1:0] arr [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Edges since the last reset edge; equals N right after the N-th scan edge.
    always @(posedge clk) begin
        scan_edges <= r_enable ? 0 : scan_edges + 1;
        rd_pend    <= rd_req;
    end

    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) fail_msg("rd_q", "host read data with nothing expected");
            else check("host_rdata", bus.controlArrRData_a, rd_q.pop_front());
        end else if (!bus.controlArr) begin
            check("rdata_idle_zero", bus.controlArrRData_a, 0);
        end
        if (bus.w_enable && !wen_prev) begin
            if (scan_q.size() == 0) begin
                fail_msg("scan_q", "w_enable rose with no scan expected");
            end else begin
                cur = scan_q.pop_front();
                check("result", bus.result, cur.res);
                check("latency", scan_edges, cur.lat);
            end
        end else if (bus.w_enable && wen_prev) begin
            check("result_stable", bus.result, last_res);
        end
        wen_prev <= bus.w_enable;
        last_res <= bus.result;
    end

    // Reference: each element costs 3 edges, 4 if it matches; the write of a
    // matching element lands on its 3rd edge and counts only within budget.
    function automatic void model_scan(input logic [WIDTH-1:0] key, input int budget,
                                       output int cnt, output int edges);
        int t = 0;
        cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ref_mem[i] == key) begin
                if (t + 3 <= budget) begin
                    ref_mem[i] = ref_mem[i] + WIDTH'(1);
                    cnt++;
                end
                t += 4;
            end else begin
                t += 3;
            end
        end
        edges = t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int a, input logic [WIDTH-1:0] d);
        bus.controlArr          = 1'b1;
        bus.controlArrWEnable_a = 1'b1;
        bus.controlArrAddr_a    = ADDR_W'(a);
        bus.controlArrWData_a   = d;
        tick();
        bus.controlArrWEnable_a = 1'b0;
        bus.controlArr          = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic load_array();
        for (int a = 0; a < DEPTH; a++) host_write(a, arr[a]);
    endtask

    task automatic host_read_all();
        bus.controlArr          = 1'b1;
        bus.controlArrWEnable_a = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            bus.controlArrAddr_a = ADDR_W'(a);
            rd_req = 1'b1;
            rd_q.push_back(ref_mem[a]);
            tick();
        end
        rd_req = 1'b0;
        tick();
        bus.controlArr = 1'b0;
    endtask

    task automatic start_scan(input logic [WIDTH-1:0] key);
        bus.init_i = key;
        r_enable   = 1'b1;
        tick();
        check("rst_w_enable", bus.w_enable, 0);
        check("rst_result", bus.result, 0);
        r_enable = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!bus.w_enable && n < 300) begin
            tick();
            n++;
        end
        if (!bus.w_enable) fail_msg(name, "w_enable=0, required 1 within 300 cycles");
        @(negedge clk);
    endtask

    task automatic scan(input logic [WIDTH-1:0] key);
        int c;
        int e;
        exp_t x;
        start_scan(key);
        model_scan(key, 1 << 30, c, e);
        x.res = c;
        x.lat = e;
        scan_q.push_back(x);
        wait_done("scan_timeout");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int c;
        int e;
        int r;
        exp_t x;
        bus.init_i              = '0;
        bus.controlArr          = 1'b0;
        bus.controlArrWEnable_a = 1'b0;
        bus.controlArrAddr_a    = '0;
        bus.controlArrWData_a   = '0;
        repeat (3) tick();
        check("reset_w_enable", bus.w_enable, 0);
        check("reset_result", bus.result, 0);

        // Host port write/readback while the kernel is held in reset.
        arr = '{8'd0, 8'd1, 8'd2, 8'd3};
        load_array();
        host_read_all();

        // Basic scan.
        arr = '{8'd5, 8'd3, 8'd5, 8'd5};
        load_array();
        scan(8'd5);
        host_read_all();

        // No matches.
        arr = '{8'd1, 8'd2, 8'd3, 8'd4};
        load_array();
        scan(8'd9);
        host_read_all();

        // Increment wraps, then a second scan on the wrapped values.
        arr = '{8'hFF, 8'hFF, 8'h00, 8'h00};
        load_array();
        scan(8'hFF);
        host_read_all();
        scan(8'h00);
        host_read_all();

        // Host stall of 3 cycles during CMP of idx=2, reading address 0.
        arr = '{8'd5, 8'd3, 8'd5, 8'd5};
        load_array();
        start_scan(8'd5);
        model_scan(8'd5, 1 << 30, c, e);
        x.res = c;
        x.lat = e + 3 + 1;
        scan_q.push_back(x);
        repeat (8) tick();
        bus.controlArr          = 1'b1;
        bus.controlArrWEnable_a = 1'b0;
        bus.controlArrAddr_a    = '0;
        rd_req = 1'b1;
        rd_q.push_back(ref_mem[0]);
        tick();
        rd_req = 1'b0;
        tick();
        tick();
        bus.controlArr = 1'b0;
        wait_done("stall_timeout");
        host_read_all();

        // Reset at scan edge 6 restarts with key 3.
        arr = '{8'd5, 8'd3, 8'd5, 8'd5};
        load_array();
        start_scan(8'd5);
        model_scan(8'd5, 5, c, e);
        repeat (5) tick();
        scan(8'd3);
        host_read_all();

        // Randomized arrays and keys from a small alphabet to force matches.
        for (int it = 0; it < 20; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                r = int'($urandom_range(0, 4));
                arr[a] = (r == 4) ? 8'hFF : WIDTH'(r);
            end
            load_array();
            r = int'($urandom_range(0, 4));
            scan((r == 4) ? 8'hFF : WIDTH'(r));
            host_read_all();
        end

        repeat (2) tick();
        check("scan_q_empty", scan_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
